// File: rtl/btb_pkg.sv
// btb_pkg: shared entry type, counter helpers and default geometry for the associative BTB.
package btb_pkg;
    localparam int ADDR_W = 32;
    localparam int SETS   = 256;
    localparam int WAYS   = 2;
    localparam int CTR_W  = 2;
    localparam int STAT_W = 32;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_INIT = {1'b1, {(CTR_W-1){1'b0}}};

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        return (|c) ? c - 1'b1 : c;
    endfunction
endpackage

// File: rtl/btb_plru.sv
// btb_plru: per-set tree-PLRU state; victim is read combinationally for query_set.
module btb_plru #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 2,
    localparam int IW = $clog2(NUM_SETS),
    localparam int WW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          touch_en,
    input  logic [IW-1:0] touch_set,
    input  logic [WW-1:0] touch_way,
    input  logic [IW-1:0] query_set,
    output logic [WW-1:0] victim_way
);
    if (NUM_WAYS == 1) begin : g_one
        logic unused_touch;
        assign unused_touch = ^{clk, reset, touch_en, touch_set, touch_way, query_set};
        assign victim_way = '0;
    end else if (NUM_WAYS == 2) begin : g_two
        logic plru_q [NUM_SETS];
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= 1'b0;
            end else if (touch_en) begin
                plru_q[touch_set] <= ~touch_way[0];
            end
        end
        assign victim_way = plru_q[query_set];
    end else begin : g_four
        // bit 0 picks the half, bits 1/2 pick within the left/right pair
        logic [2:0] plru_q [NUM_SETS];
        logic [2:0] plru_d;
        logic [2:0] q_bits;
        always_comb begin
            plru_d = plru_q[touch_set];
            plru_d[0] = ~touch_way[1];
            plru_d[1] = touch_way[1] ? plru_d[1] : ~touch_way[0];
            plru_d[2] = touch_way[1] ? ~touch_way[0] : plru_d[2];
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int s = 0; s < NUM_SETS; s++) plru_q[s] <= '0;
            end else if (touch_en) begin
                plru_q[touch_set] <= plru_d;
            end
        end
        assign q_bits = plru_q[query_set];
        assign victim_way = q_bits[0] ? {1'b1, q_bits[2]} : {1'b0, q_bits[1]};
    end
endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative BTB with saturating direction counters, PLRU replacement,
// flush and a saturating hit counter; lookup is combinational off the pre-update state.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int NUM_SETS   = SETS,
    parameter int NUM_WAYS   = WAYS,
    parameter int CTR_WIDTH  = CTR_W,
    parameter int STAT_WIDTH = STAT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_en,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  update_valid,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    input  logic                  flush,
    output logic [STAT_WIDTH-1:0] stat_hits
);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = ADDR_WIDTH - IW - 2;
    localparam int WW = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;

    btb_entry_t            mem_q [NUM_SETS][NUM_WAYS];
    btb_entry_t            l_ent, u_ent, ent_d;
    logic [STAT_WIDTH-1:0] stat_q;
    logic [IW-1:0]         l_idx, u_idx;
    logic [TW-1:0]         l_tag, u_tag;
    logic [WW-1:0]         l_way, u_way, free_way, victim_way, wr_way;
    logic                  l_hit, u_hit, u_free, do_write;
    logic [3:0]            unused_pc;

    assign l_idx     = lookup_pc[IW+1:2];
    assign l_tag     = lookup_pc[ADDR_WIDTH-1:IW+2];
    assign u_idx     = update_pc[IW+1:2];
    assign u_tag     = update_pc[ADDR_WIDTH-1:IW+2];
    assign unused_pc = {lookup_pc[1:0], update_pc[1:0]};

    // Descending scan so the lowest matching/free way is the one left standing
    always_comb begin
        l_hit = 1'b0;
        l_way = '0;
        u_hit = 1'b0;
        u_way = '0;
        u_free = 1'b0;
        free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (mem_q[l_idx][w].valid && mem_q[l_idx][w].tag == l_tag) begin
                l_hit = 1'b1;
                l_way = WW'(w);
            end
            if (mem_q[u_idx][w].valid && mem_q[u_idx][w].tag == u_tag) begin
                u_hit = 1'b1;
                u_way = WW'(w);
            end
            if (!mem_q[u_idx][w].valid) begin
                u_free = 1'b1;
                free_way = WW'(w);
            end
        end
    end

    assign l_ent       = mem_q[l_idx][l_way];
    assign pred_hit    = lookup_en & l_hit;
    assign pred_taken  = pred_hit & l_ent.ctr[CTR_WIDTH-1];
    assign pred_target = pred_hit ? l_ent.target : '0;

    assign wr_way   = u_hit ? u_way : (u_free ? free_way : victim_way);
    assign u_ent    = mem_q[u_idx][wr_way];
    assign do_write = update_valid & ~flush & (u_hit | update_taken);

    always_comb begin
        ent_d = u_ent;
        ent_d.ctr = update_taken ? ctr_inc(u_ent.ctr) : ctr_dec(u_ent.ctr);
        ent_d.target = update_taken ? update_target : u_ent.target;
        if (!u_hit) ent_d = '{valid: 1'b1, tag: u_tag, target: update_target, ctr: CTR_INIT};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++) mem_q[s][w] <= '0;
            stat_q <= '0;
        end else begin
            if (flush) begin
                for (int s = 0; s < NUM_SETS; s++)
                    for (int w = 0; w < NUM_WAYS; w++) mem_q[s][w].valid <= 1'b0;
            end else if (do_write) begin
                mem_q[u_idx][wr_way] <= ent_d;
            end
            if (pred_hit && !(&stat_q)) stat_q <= stat_q + 1'b1;
        end
    end

    assign stat_hits = stat_q;

    btb_plru #(
        .NUM_SETS(NUM_SETS),
        .NUM_WAYS(NUM_WAYS)
    ) u_plru (
        .clk       (clk),
        .reset     (reset),
        .touch_en  (do_write),
        .touch_set (u_idx),
        .touch_way (wr_way),
        .query_set (u_idx),
        .victim_way(victim_way)
    );
endmodule
